count_ctrl_seq: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit loadable up-counter and drives its P, Load and Enable control lines. It accepts load, run and run-until commands over a valid/ready handshake. It watches the counter's Q output to finish run-until commands, and reports completion, timeout and abort status to the test or system controller.

---
 rtl/count_ctrl_seq.sv | 213 +++++++++++++++++++++
 tb/tb_count_ctrl_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl_seq.sv
// count_ctrl_seq
// Command sequencer that drives the P / Load / Enable control lines of a
// loadable up-counter. Commands (NOP, LOAD, RUN, RUN_UNTIL) arrive over a
// valid/ready handshake. RUN_UNTIL stops when the counter's Q output
// reaches the target. Completion, timeout and abort are reported as
// one-cycle registered pulses.
//
// Ports:
//   clk        rising-edge clock, shared with the counter
//   MR         master reset, asynchronous, active-high
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE and not in reset)
//   cmd_op     00 NOP, 01 LOAD, 10 RUN, 11 RUN_UNTIL
//   cmd_data   LOAD value / RUN_UNTIL target
//   cmd_len    RUN cycle count
//   abort      terminate RUN / RUN_UNTIL early
//   Q          counter output (registered inside the counter)
//   P          parallel-load value to the counter
//   Load       counter synchronous load strobe
//   Enable     counter count enable
//   busy       command in progress
//   done       one-cycle completion pulse
//   err        one-cycle timeout pulse, coincident with done
//   aborted    one-cycle abort pulse, coincident with done
module count_ctrl_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int TMO   = 16   // should be >= 2**WIDTH so a free-running counter always matches
) (
  input  logic             clk,
  input  logic             MR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] P,
  output logic             Load,
  output logic             Enable,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  localparam int TMO_W = $clog2(TMO) + 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_UNTIL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_UNTIL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;

  logic               accept_s;
  logic               match_s;
  logic               last_run_s;
  logic               enable_s;
  logic               load_s;

  // Ready is gated by MR so it reads 0 for the whole time reset is held.
  assign cmd_ready  = (state_q == S_IDLE) & ~MR;
  assign accept_s   = cmd_valid & cmd_ready;
  assign match_s    = (Q == tgt_q);
  assign last_run_s = (len_q == LEN_W'(1));

  // Next-state, latched-field and control-line logic.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    tgt_d     = tgt_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    enable_s  = 1'b0;
    load_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_NOP: begin
              state_d = S_DONE;
            end
            OP_LOAD: begin
              p_d     = cmd_data;
              state_d = S_LOAD;
            end
            OP_RUN: begin
              len_d = cmd_len;
              if (cmd_len == LEN_W'(0)) begin
                state_d = S_DONE;
              end else begin
                state_d = S_RUN;
              end
            end
            OP_UNTIL: begin
              tgt_d   = cmd_data;
              tmo_d   = TMO_W'(0);
              state_d = S_UNTIL;
            end
            default: begin
              state_d = S_DONE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        load_s  = 1'b1;
        state_d = S_DONE;
      end

      S_RUN: begin
        // An abort on the final cycle is ignored: the run is already complete.
        if (abort && !last_run_s) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          enable_s = 1'b1;
          len_d    = len_q - LEN_W'(1);
          if (last_run_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_UNTIL: begin
        // Match takes priority over abort; Enable is withheld on a match
        // so the counter never passes the target.
        if (match_s) begin
          state_d = S_DONE;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          enable_s = 1'b1;
          tmo_d    = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_W'(TMO - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_UNTIL;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State, latched command fields and registered status pulses.
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      tgt_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      tgt_q     <= tgt_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign P       = p_q;
  assign Load    = load_s;
  assign Enable  = enable_s;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_count_ctrl_seq.sv
// Directed bench for count_ctrl_seq with a behavioural 4-bit loadable
// counter closing the Q loop. The counter can be frozen to force a
// RUN_UNTIL timeout.
module tb_count_ctrl_seq;

  logic       clk = 1'b0;
  logic       MR;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic       abort;
  logic [3:0] Q;
  logic [3:0] P;
  logic       Load, Enable, busy, done, err, aborted;
  logic       freeze;

  int passed = 0;
  int total  = 0;
  int en_cnt = 0, ld_cnt = 0, dn_cnt = 0, ovl_cnt = 0;
  int e0, l0, d0, lat;

  count_ctrl_seq #(.WIDTH(4), .LEN_W(8), .TMO(16)) dut (
    .clk(clk), .MR(MR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
    .Q(Q), .P(P), .Load(Load), .Enable(Enable), .busy(busy),
    .done(done), .err(err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Counter under control of the sequencer.
  always @(posedge clk or posedge MR) begin
    if (MR) Q <= 4'd0;
    else if (Load) Q <= P;
    else if (Enable && !freeze) Q <= Q + 4'd1;
  end

  // Edge-sampled activity counters.
  always @(posedge clk) begin
    if (Enable) en_cnt <= en_cnt + 1;
    if (Load) ld_cnt <= ld_cnt + 1;
    if (done) dn_cnt <= dn_cnt + 1;
    if (Load && Enable) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int l);
    l = 0;
    while (done !== 1'b1 && l < maxc) begin
      @(negedge clk);
      l++;
    end
  endtask

  // One cycle after done: pulse gone, back in IDLE.
  task automatic post(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    MR = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
    cmd_len = 8'd0; abort = 1'b0; freeze = 1'b0;

    // Reset held for 3 cycles
    #1;
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_P", P, 4'd0);
    chk("rst_en", Enable, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    MR = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1'b1);
    @(negedge clk);

    // LOAD 0111
    l0 = ld_cnt; d0 = dn_cnt;
    send(2'b01, 4'b0111, 8'd0);
    chk("ld_load", Load, 1'b1);
    chk("ld_P", P, 4'b0111);
    chk("ld_en", Enable, 1'b0);
    chk("ld_ready", cmd_ready, 1'b0);
    wait_done(10, lat);
    chk("ld_lat", lat, 1);
    chk("ld_Q", Q, 4'b0111);
    post("ld");
    chk("ld_cnt", ld_cnt - l0, 1);
    chk("ld_dones", dn_cnt - d0, 1);
    chk("ld_P_hold", P, 4'b0111);

    // RUN 5
    e0 = en_cnt; d0 = dn_cnt;
    send(2'b10, 4'd0, 8'd5);
    wait_done(20, lat);
    chk("r5_lat", lat, 5);
    chk("r5_Q", Q, 4'b1100);
    chk("r5_err", err, 1'b0);
    post("r5");
    chk("r5_en", en_cnt - e0, 5);
    chk("r5_dones", dn_cnt - d0, 1);

    // RUN 0
    e0 = en_cnt;
    send(2'b10, 4'd0, 8'd0);
    wait_done(10, lat);
    chk("r0_lat", lat, 0);
    post("r0");
    chk("r0_en", en_cnt - e0, 0);

    // RUN 255: Q = 12 + 255 mod 16 = 11
    e0 = en_cnt;
    send(2'b10, 4'd0, 8'd255);
    wait_done(300, lat);
    chk("r255_lat", lat, 255);
    post("r255");
    chk("r255_en", en_cnt - e0, 255);
    chk("r255_Q", Q, 4'd11);

    // LOAD 0, RUN_UNTIL 9
    send(2'b01, 4'd0, 8'd0);
    wait_done(10, lat);
    post("ld0");
    chk("ld0_Q", Q, 4'd0);
    e0 = en_cnt;
    send(2'b11, 4'd9, 8'd0);
    wait_done(40, lat);
    chk("u9_lat", lat, 10);
    chk("u9_err", err, 1'b0);
    chk("u9_abt", aborted, 1'b0);
    post("u9");
    chk("u9_en", en_cnt - e0, 9);
    chk("u9_Q", Q, 4'd9);

    // RUN_UNTIL with target already reached
    e0 = en_cnt;
    send(2'b11, 4'd9, 8'd0);
    chk("ueq_en_now", Enable, 1'b0);
    wait_done(10, lat);
    chk("ueq_lat", lat, 1);
    post("ueq");
    chk("ueq_en", en_cnt - e0, 0);

    // Timeout: counter frozen at 3, target 8
    send(2'b01, 4'd3, 8'd0);
    wait_done(10, lat);
    post("ld3");
    freeze = 1'b1;
    e0 = en_cnt;
    send(2'b11, 4'd8, 8'd0);
    wait_done(40, lat);
    chk("tmo_lat", lat, 16);
    chk("tmo_err", err, 1'b1);
    chk("tmo_done", done, 1'b1);
    chk("tmo_abt", aborted, 1'b0);
    post("tmo");
    chk("tmo_en", en_cnt - e0, 16);
    chk("tmo_err_low", err, 1'b0);
    freeze = 1'b0;

    // Abort RUN 20 on the 7th Enable cycle: Q = 3 + 6 = 9
    e0 = en_cnt;
    send(2'b10, 4'd0, 8'd20);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("ab_en_low", Enable, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_done", done, 1'b1);
    chk("ab_aborted", aborted, 1'b1);
    chk("ab_err", err, 1'b0);
    chk("ab_Q", Q, 4'd9);
    post("ab");
    chk("ab_en", en_cnt - e0, 6);

    // Abort coinciding with match in RUN_UNTIL: 9 -> 11
    send(2'b11, 4'd11, 8'd0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("am_en_low", Enable, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    chk("am_done", done, 1'b1);
    chk("am_aborted", aborted, 1'b0);
    chk("am_Q", Q, 4'd11);
    post("am");

    // Abort on the last RUN cycle is ignored: Q = 11 + 3 = 14
    e0 = en_cnt;
    send(2'b10, 4'd0, 8'd3);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("al_en_high", Enable, 1'b1);
    @(negedge clk);
    abort = 1'b0;
    chk("al_done", done, 1'b1);
    chk("al_aborted", aborted, 1'b0);
    chk("al_Q", Q, 4'd14);
    post("al");
    chk("al_en", en_cnt - e0, 3);

    // NOP
    send(2'b00, 4'd0, 8'd0);
    chk("nop_done", done, 1'b1);
    post("nop");

    // Reset mid-RUN 200
    send(2'b10, 4'd0, 8'd200);
    repeat (49) @(negedge clk);
    chk("mr_pre_en", Enable, 1'b1);
    MR = 1'b1;
    #1;
    chk("mr_en", Enable, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_P", P, 4'd0);
    chk("mr_ready", cmd_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("mr_hold_ready", cmd_ready, 1'b0);
    MR = 1'b0;
    #1;
    chk("mr_rel_ready", cmd_ready, 1'b1);
    chk("mr_rel_done", done, 1'b0);
    @(negedge clk);
    send(2'b00, 4'd0, 8'd0);
    chk("mr_nop_done", done, 1'b1);
    post("mr_nop");

    chk("no_overlap", ovl_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
